// File: rtl/goods_key_pkg.sv
// -----------------------------------------------------------------------------
// goods_key_pkg
// Shared definitions for the vending-machine front-panel key entry block:
//   - key index map (digits 0-7, quantity, confirm, cancel, coins)
//   - one-hot entry state encoding
//   - quantity codes and the selection record
//   - small key-classification helpers
// -----------------------------------------------------------------------------
package goods_key_pkg;

    localparam int unsigned NUM_KEYS = 16;

    // Key index map (keys 0-7 are digits 0-7)
    localparam logic [3:0] KEY_QTY1    = 4'd8;
    localparam logic [3:0] KEY_QTY2    = 4'd9;
    localparam logic [3:0] KEY_QTY3    = 4'd10;
    localparam logic [3:0] KEY_CONFIRM = 4'd11;
    localparam logic [3:0] KEY_CANCEL  = 4'd12;
    localparam logic [3:0] KEY_COIN1   = 4'd13;
    localparam logic [3:0] KEY_COIN5   = 4'd14;
    localparam logic [3:0] KEY_COIN10  = 4'd15;

    // Entry state encoding, one-hot
    localparam logic [4:0] E_HIGH  = 5'b00001;
    localparam logic [4:0] E_LOW   = 5'b00010;
    localparam logic [4:0] E_NUM   = 5'b00100;
    localparam logic [4:0] E_CONF  = 5'b01000;
    localparam logic [4:0] E_VALID = 5'b10000;

    // Quantity codes; zero means "not yet entered"
    localparam logic [1:0] QTY_NONE = 2'd0;
    localparam logic [1:0] QTY_1    = 2'd1;
    localparam logic [1:0] QTY_2    = 2'd2;
    localparam logic [1:0] QTY_3    = 2'd3;

    typedef struct packed {
        logic [2:0] high;
        logic [2:0] low;
        logic [1:0] num;
    } sel_t;

    localparam sel_t SEL_CLEAR = '{high: 3'd0, low: 3'd0, num: 2'd0};

    function automatic logic is_digit(input logic [3:0] idx);
        return (idx[3] == 1'b0);
    endfunction

    function automatic logic is_coin(input logic [3:0] idx);
        return (idx >= KEY_COIN1);
    endfunction

    function automatic logic [1:0] qty_code(input logic [3:0] idx);
        logic [1:0] code;
        case (idx)
            KEY_QTY1: code = QTY_1;
            KEY_QTY2: code = QTY_2;
            KEY_QTY3: code = QTY_3;
            default:  code = QTY_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/goods_key_entry_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Single-key 2-FF synchroniser followed by a tick-based debounce counter.
// The counter clears whenever the synced level matches the accepted level,
// otherwise counts ms ticks; after DEBOUNCE_MS ticks the accepted level flips.
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous active-low reset
//   tick_i   shared 1 ms tick (one cycle wide)
//   key_i    raw asynchronous key, active-high
//   level_o  debounced level
//   press_o  one-cycle pulse on a debounced 0->1 transition
// -----------------------------------------------------------------------------
module key_debounce
    import goods_key_pkg::*;
#(
    parameter logic [7:0] DEBOUNCE_MS = 8'd20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic key_i,
    output logic level_o,
    output logic press_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic [7:0] cnt_q, cnt_d;

    // Debounce next-state: count ticks while the synced level disagrees
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = 8'd0;
        end else if (tick_i) begin
            if ((cnt_q + 8'd1) >= DEBOUNCE_MS) begin
                level_d = sync2_q;
                press_d = sync2_q;   // only the rising flip is a press
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Synchroniser and debounce state registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/goods_key_entry.sv
// -----------------------------------------------------------------------------
// goods_key_entry
// Front-panel input block: debounces 16 push-buttons, assembles a goods
// selection (high digit, low digit, quantity) with an entry FSM, hands it off
// over a valid/ready handshake, and emits one-cycle coin pulses.
// Ports:
//   sys_clk, sys_rst_n    clock, synchronous active-low reset
//   key_in[15:0]          raw buttons (asynchronous, active-high)
//   sel_ready             downstream FSM accepts the selection
//   sel_valid             completed selection available
//   out_goods_high/low    goods digits (live during entry)
//   out_goods_num         quantity 1..3, 0 = not entered
//   coin_pulse[2:0]       [0]=1 yuan, [1]=5 yuan, [2]=10 yuan
//   entry_busy            entry in progress
//   key_level[15:0]       debounced key levels
// Optional feature macro: GOODS_KEY_TIMEOUT_EN (idle-entry timeout acting as
// cancel in E_LOW/E_NUM/E_CONF).
// -----------------------------------------------------------------------------
module goods_key_entry
    import goods_key_pkg::*;
#(
    parameter logic [15:0] CNT_1MS     = 16'd49_999,
    parameter logic [7:0]  DEBOUNCE_MS = 8'd20,
    parameter logic [15:0] TIMEOUT_MS  = 16'd10_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] key_in,
    input  logic        sel_ready,
    output logic        sel_valid,
    output logic [2:0]  out_goods_high,
    output logic [2:0]  out_goods_low,
    output logic [1:0]  out_goods_num,
    output logic [2:0]  coin_pulse,
    output logic        entry_busy,
    output logic [15:0] key_level
);

    logic [15:0] ms_cnt_q, ms_cnt_d;
    logic        ms_tick_q, ms_tick_d;
    logic [15:0] press_s;
    logic        ev_valid_s;
    logic [3:0]  ev_idx_s;
    logic        ev_entry_s;     // processed event that is not a coin key
    logic        cancel_s;
    logic        timeout_s;
    logic [4:0]  state_q, state_d;
    sel_t        sel_q, sel_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic [2:0]  coin_q, coin_d;

    // Free-running ms counter; tick is registered and lasts one cycle per wrap
    always_comb begin
        ms_tick_d = (ms_cnt_q == CNT_1MS);
        ms_cnt_d  = ms_tick_d ? 16'd0 : (ms_cnt_q + 16'd1);
    end

    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_key
            key_debounce #(
                .DEBOUNCE_MS (DEBOUNCE_MS)
            ) u_key_debounce (
                .clk_i   (sys_clk),
                .rst_ni  (sys_rst_n),
                .tick_i  (ms_tick_q),
                .key_i   (key_in[g]),
                .level_o (key_level[g]),
                .press_o (press_s[g])
            );
        end
    endgenerate

    // Lowest-index press wins; simultaneous higher-index presses are dropped
    always_comb begin
        ev_valid_s = 1'b0;
        ev_idx_s   = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            ev_valid_s = press_s[i] ? 1'b1  : ev_valid_s;
            ev_idx_s   = press_s[i] ? 4'(i) : ev_idx_s;
        end
        ev_entry_s = ev_valid_s && !is_coin(ev_idx_s);
    end

`ifdef GOODS_KEY_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        in_entry_s;

    // Idle timeout: runs only while a partial entry is pending
    always_comb begin
        in_entry_s = (state_q == E_LOW) || (state_q == E_NUM) || (state_q == E_CONF);
        timeout_s  = in_entry_s && (to_cnt_q >= TIMEOUT_MS);
        if (!in_entry_s || ev_entry_s) begin
            to_cnt_d = 16'd0;
        end else if (ms_tick_q) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    // Timeout counter register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            to_cnt_q <= 16'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_MS;
    assign timeout_s        = 1'b0;
`endif

    assign cancel_s = (ev_entry_s && (ev_idx_s == KEY_CANCEL)) || timeout_s;

    // Coin pulses are independent of the entry FSM
    always_comb begin
        coin_d = 3'b000;
        if (ev_valid_s) begin
            case (ev_idx_s)
                KEY_COIN1:  coin_d = 3'b001;
                KEY_COIN5:  coin_d = 3'b010;
                KEY_COIN10: coin_d = 3'b100;
                default:    coin_d = 3'b000;
            endcase
        end else begin
            coin_d = 3'b000;
        end
    end

    // Entry FSM next-state and field updates
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            E_HIGH: begin
                if (cancel_s) begin
                    sel_d = SEL_CLEAR;
                end else if (ev_entry_s && is_digit(ev_idx_s)) begin
                    sel_d.high = ev_idx_s[2:0];
                    state_d    = E_LOW;
                end else begin
                    state_d = E_HIGH;
                end
            end
            E_LOW: begin
                if (cancel_s) begin
                    sel_d   = SEL_CLEAR;
                    state_d = E_HIGH;
                end else if (ev_entry_s && is_digit(ev_idx_s)) begin
                    sel_d.low = ev_idx_s[2:0];
                    state_d   = E_NUM;
                end else begin
                    state_d = E_LOW;
                end
            end
            E_NUM: begin
                if (cancel_s) begin
                    sel_d   = SEL_CLEAR;
                    state_d = E_HIGH;
                end else if (ev_entry_s && (qty_code(ev_idx_s) != QTY_NONE)) begin
                    sel_d.num = qty_code(ev_idx_s);
                    state_d   = E_CONF;
                end else begin
                    state_d = E_NUM;
                end
            end
            E_CONF: begin
                if (cancel_s) begin
                    sel_d   = SEL_CLEAR;
                    state_d = E_HIGH;
                end else if (ev_entry_s && (qty_code(ev_idx_s) != QTY_NONE)) begin
                    sel_d.num = qty_code(ev_idx_s);
                end else if (ev_entry_s && (ev_idx_s == KEY_CONFIRM)) begin
                    state_d = E_VALID;
                end else begin
                    state_d = E_CONF;
                end
            end
            E_VALID: begin
                // Fields frozen; only the handshake leaves this state
                if (valid_q && sel_ready) begin
                    sel_d   = SEL_CLEAR;
                    state_d = E_HIGH;
                end else begin
                    state_d = E_VALID;
                end
            end
            default: begin
                sel_d   = SEL_CLEAR;
                state_d = E_HIGH;
            end
        endcase
        valid_d = (state_d == E_VALID);
        busy_d  = (state_d != E_HIGH) || (sel_d != SEL_CLEAR);
    end

    // All state and output registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            ms_cnt_q  <= 16'd0;
            ms_tick_q <= 1'b0;
            state_q   <= E_HIGH;
            sel_q     <= SEL_CLEAR;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            coin_q    <= 3'b000;
        end else begin
            ms_cnt_q  <= ms_cnt_d;
            ms_tick_q <= ms_tick_d;
            state_q   <= state_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            coin_q    <= coin_d;
        end
    end

    assign sel_valid      = valid_q;
    assign out_goods_high = sel_q.high;
    assign out_goods_low  = sel_q.low;
    assign out_goods_num  = sel_q.num;
    assign coin_pulse     = coin_q;
    assign entry_busy     = busy_q;

endmodule

// File: doc/goods_key_entry.md
Name: goods_key_entry

Overview:
Front-panel input block for the vending machine. It synchronises and debounces the 16 panel push-buttons, then assembles a goods selection (high code, low code, quantity) through a small entry state machine. It hands the completed selection to the main vending FSM with a valid/ready handshake and emits single-cycle coin-insert pulses. Its selection outputs drive the goods inputs of the LED/RGB display block.

Parameters:
CNT_1MS, 16'd49_999, sys_clk cycles per 1 ms tick minus one (50 MHz clock).
DEBOUNCE_MS, 8'd20, consecutive ms ticks a key level must hold before it is accepted.
TIMEOUT_MS, 16'd10_000, idle-entry timeout in ms; used only with the optional feature.

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  synchronous, active-low reset
key_in  in  16  raw buttons, active-high, asynchronous
sel_ready  in  1  FSM accepts the selection
sel_valid  out  1  completed selection available
out_goods_high  out  3  first goods digit
out_goods_low  out  3  second goods digit
out_goods_num  out  2  quantity, 1..3; 0 means not yet entered
coin_pulse  out  3  one-cycle pulses: [0]=1 yuan, [1]=5, [2]=10
entry_busy  out  1  entry in progress (state not E_HIGH, or E_HIGH with a partial field)
key_level  out  16  debounced key levels

Behaviour:
- Reset: one clock, synchronous, active-low; the reset and polarity are fixed. While sys_rst_n=0 at a sys_clk edge, all outputs go to 0, all counters clear, debounced levels go to 0, and the state goes to E_HIGH. A reset asserted mid-entry discards any partial selection.
- ms tick: free-running counter 0..CNT_MAX; a one-cycle tick occurs when the counter wraps.
- Per key: 2-FF synchroniser, then a debounce counter.
  - The counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments on each tick.
  - At DEBOUNCE_MS, the debounced level flips and the counter clears.
- Press event: debounced 0->1 transition, one cycle wide.
- Simultaneous press events in one cycle: only the lowest key index is processed; the others are dropped (not queued).
- Key map:
  - 0-7: digit 0-7.
  - 8/9/10: quantity 1/2/3.
  - 11: confirm.
  - 12: cancel.
  - 13/14/15: coin 1/5/10.
- Coin keys act in every state and do not affect the entry FSM. The coin_pulse bit is registered, so it asserts 1 cycle after the press event.
- Entry FSM:
  - E_HIGH: a digit loads out_goods_high and moves to E_LOW.
  - E_LOW: a digit loads out_goods_low and moves to E_NUM.
  - E_NUM: a quantity key loads out_goods_num and moves to E_CONF.
  - E_CONF: a quantity key overwrites out_goods_num and stays; confirm moves to E_VALID and sets sel_valid=1 on the next cycle.
  - E_VALID: sel_valid held high and all fields held stable. All keys except coins are ignored, including cancel. On sel_valid & sel_ready, clear all fields, drop sel_valid, and return to E_HIGH on the next cycle.
  - Cancel in E_HIGH..E_CONF: clear all fields and go to E_HIGH.
  - Keys that do not apply to the current state are ignored.
- Fields are visible live while entry is in progress, so the display shows partial selections.
- sel_ready outside E_VALID has no effect.

Optional Feature:
Macro GOODS_KEY_TIMEOUT_EN.
- Defined: in states E_LOW, E_NUM and E_CONF, an ms counter runs and clears on any processed non-coin press event. Reaching TIMEOUT_MS acts exactly as cancel. E_VALID never times out.
- Undefined: no timeout counter is built; partial entries persist indefinitely.

Decomposition:
- Shared package goods_key_pkg holds:
  - key index localparams (KEY_CONFIRM=11, KEY_CANCEL=12, KEY_COIN1=13, ...);
  - the entry state encoding (one-hot, 5 bits);
  - quantity codes.
- One natural sub-module, key_debounce: a single-key synchroniser and debounce counter sharing the ms tick. It is instantiated 16 times via generate.

Test Plan:
- Sim with CNT_1MS=4 and DEBOUNCE_MS=2. Hold key 3 for 20 cycles, then release:
  - exactly one press event;
  - out_goods_high=3, state E_LOW.
- Key glitch of 3 cycles on key 5:
  - key_level[5] stays 0;
  - no field change.
- Press 2, 6, 9, 10, 11 with sel_ready=0:
  - sel_valid=1 with high=2, low=6, num=3;
  - values held for 50 cycles.
- Assert sel_ready=1 for 1 cycle:
  - next cycle sel_valid=0 and all fields 0.
- Press keys 1 and 4 in the same cycle from E_HIGH:
  - high=1;
  - key 4 is dropped.
- Enter 7, 0, then press cancel (key 12):
  - fields return to 0 and state to E_HIGH.
- Press key 14 during E_NUM:
  - coin_pulse=3'b010 for exactly 1 cycle;
  - state unchanged.
- Assert sys_rst_n=0 during E_CONF:
  - all outputs 0 at the next edge.
